tile_locator: RTL and testbench
===============================

Name: tile_locator

Overview:
- Inverse of the glyph/tile drawers: those turn a tile position plus a glyph offset into screen pixels; this block turns a screen pixel (from cursor or mouse logic) back into a tile.
- Maps a screen coordinate (xIn 8-bit, yIn 7-bit) onto the 4x4 sliding-puzzle board.
- Outputs tile column, row, linear index, in-tile offset and a hit flag.
- Uses iterative subtraction, not dividers. Valid/ready handshake on both sides.
- Sits between cursor/input logic and the game-board control FSM.

Parameters:
- X0, 36, board left edge in pixels (8-bit).
- Y0, 4, board top edge in pixels (7-bit).
- TILE, 28, tile pitch in pixels, 1..31. X0+4*TILE must be ≤ 255 and Y0+4*TILE ≤ 127.
- GAP, 2, border pixels at the right/bottom of each tile. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- xIn  in  8  query x pixel.
- yIn  in  7  query y pixel.
- in_valid  in  1  query present.
- in_ready  out  1  block idle; query accepted on in_valid&&in_ready.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- hit  out  1  pixel lies on a tile.
- tile_col  out  2  column 0..3.
- tile_row  out  2  row 0..3.
- tile_idx  out  4  row*4+col.
- x_off  out  5  xIn - X0 - col*TILE.
- y_off  out  5  yIn - Y0 - row*TILE.

Behaviour:
- Reset (synchronous, active-high, wins over everything, legal in any state):
  - state=IDLE, out_valid=0, hit=0.
  - col/row/idx/offsets=0, internal counters and remainders=0.
  - in_ready=1 from the first cycle after reset deasserts.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. All outputs are registered.
- State machine:
  - IDLE: on in_valid, latch rem_x=xIn-X0 and rem_y=yIn-Y0 as 9-bit values (borrow kept), clear counters, go to CHECK.
  - CHECK: miss if borrow set, rem_x ≥ 4*TILE, or rem_y ≥ 4*TILE.
    - Miss: go to DONE with hit=0 and col/row/idx/offsets=0.
    - Otherwise go to DIV.
  - DIV: each cycle, in parallel:
    - if rem_x ≥ TILE: rem_x -= TILE, col++;
    - if rem_y ≥ TILE: rem_y -= TILE, row++.
    - When neither applies: register hit=1, col, row, idx={row,col}, x_off=rem_x[4:0], y_off=rem_y[4:0], and go to DONE.
  - DONE: hold all outputs stable. On out_ready go to IDLE; out_valid drops on the same edge.
- Latency, counted from the accepting edge:
  - hit: out_valid rises k+2 edges later, k = max(col,row), so 2..5;
  - miss: 1 edge later.
- Throughput: in IDLE the next accept happens no earlier than the edge after the DONE→IDLE edge. Accept and release never share a cycle.
- in_valid while busy is ignored, with no queuing.
- out_ready while not in DONE has no effect.
- Counters saturate structurally at 3 because range is checked first, so they never wrap.
- Pixel exactly at X0+4*TILE or Y0+4*TILE is a miss. The last hit pixel is X0+4*TILE-1.

Optional Feature:
- Macro: TILE_LOCATOR_GAP_EN.
- Defined: on leaving DIV, if rem_x ≥ TILE-GAP or rem_y ≥ TILE-GAP, result is a miss: hit=0, col/row/idx/offsets=0, same latency as a hit.
- Undefined: GAP is ignored and every in-board pixel is a hit.

Test Plan:
- (36,4) → hit=1, col=0, row=0, idx=0, x_off=0, y_off=0; out_valid 2 edges after accept.
- (147,115) → hit=1, col=3, row=3, idx=15, x_off=27, y_off=27; out_valid 5 edges after accept.
- (100,40) → hit=1, col=2, row=1, idx=6, x_off=8, y_off=8; latency 4.
- (35,50) and (148,50) → each hit=0, all fields 0; latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles with in_valid=1 and changing xIn: outputs stable, in_ready=0, no new accept.
  - Release out_ready: in_ready=1 the next cycle.
  - Pulse reset during DIV: next cycle IDLE, out_valid=0, all outputs 0.
- (63,10):
  - TILE_LOCATOR_GAP_EN defined → hit=0, all fields 0.
  - Undefined → hit=1, col=0, x_off=27.

Source files
------------

// File: rtl/tile_locator.sv
// Maps a screen pixel onto a 4x4 tile board using iterative subtraction.
// Optional macro TILE_LOCATOR_GAP_EN turns pixels in each tile's right/bottom border into misses.
module tile_locator #(
  parameter logic [7:0] X0   = 8'd36,
  parameter logic [6:0] Y0   = 7'd4,
  parameter logic [4:0] TILE = 5'd28,
  parameter logic [4:0] GAP  = 5'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] xIn,
  input  logic [6:0] yIn,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       hit,
  output logic [1:0] tile_col,
  output logic [1:0] tile_row,
  output logic [3:0] tile_idx,
  output logic [4:0] x_off,
  output logic [4:0] y_off
);

  // state | meaning
  // IDLE  | waiting for a query, in_ready high
  // CHECK | range test on the latched remainders
  // DIV   | subtract one tile pitch per axis per cycle
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  localparam logic [8:0] TILE9   = {4'd0, TILE};
  localparam logic [8:0] SPAN9   = {2'd0, TILE, 2'd0};
  localparam logic [8:0] GAP_LIM = TILE9 - {4'd0, GAP};

  state_t     state_q, state_d;
  logic [8:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [1:0] cnt_col_q, cnt_col_d, cnt_row_q, cnt_row_d;
  logic       hit_q, hit_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [4:0] x_off_q, x_off_d, y_off_q, y_off_d;
  logic       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic       sub_x, sub_y, out_of_board, gap_miss;

  // Bit 8 of each remainder is the borrow from subtracting the board origin.
  assign sub_x        = rem_x_q >= TILE9;
  assign sub_y        = rem_y_q >= TILE9;
  assign out_of_board = rem_x_q[8] || rem_y_q[8] || (rem_x_q >= SPAN9) || (rem_y_q >= SPAN9);

`ifdef TILE_LOCATOR_GAP_EN
  assign gap_miss = (rem_x_q >= GAP_LIM) || (rem_y_q >= GAP_LIM);
`else
  assign gap_miss = 1'b0 && (GAP_LIM != 9'd0);
`endif

  always_comb begin
    state_d     = state_q;
    rem_x_d     = rem_x_q;
    rem_y_d     = rem_y_q;
    cnt_col_d   = cnt_col_q;
    cnt_row_d   = cnt_row_q;
    hit_d       = hit_q;
    col_d       = col_q;
    row_d       = row_q;
    x_off_d     = x_off_q;
    y_off_d     = y_off_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_x_d    = {1'b0, xIn} - {1'b0, X0};
          rem_y_d    = {2'b0, yIn} - {2'b0, Y0};
          cnt_col_d  = 2'd0;
          cnt_row_d  = 2'd0;
          in_ready_d = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (out_of_board) begin
          hit_d       = 1'b0;
          col_d       = 2'd0;
          row_d       = 2'd0;
          x_off_d     = 5'd0;
          y_off_d     = 5'd0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (sub_x) begin
          rem_x_d   = rem_x_q - TILE9;
          cnt_col_d = cnt_col_q + 2'd1;
        end
        if (sub_y) begin
          rem_y_d   = rem_y_q - TILE9;
          cnt_row_d = cnt_row_q + 2'd1;
        end
        if (!sub_x && !sub_y) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
          if (gap_miss) begin
            hit_d   = 1'b0;
            col_d   = 2'd0;
            row_d   = 2'd0;
            x_off_d = 5'd0;
            y_off_d = 5'd0;
          end else begin
            hit_d   = 1'b1;
            col_d   = cnt_col_q;
            row_d   = cnt_row_q;
            x_off_d = rem_x_q[4:0];
            y_off_d = rem_y_q[4:0];
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_x_q     <= 9'd0;
      rem_y_q     <= 9'd0;
      cnt_col_q   <= 2'd0;
      cnt_row_q   <= 2'd0;
      hit_q       <= 1'b0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      x_off_q     <= 5'd0;
      y_off_q     <= 5'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_x_q     <= rem_x_d;
      rem_y_q     <= rem_y_d;
      cnt_col_q   <= cnt_col_d;
      cnt_row_q   <= cnt_row_d;
      hit_q       <= hit_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x_off_q     <= x_off_d;
      y_off_q     <= y_off_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign tile_col  = col_q;
  assign tile_row  = row_q;
  assign tile_idx  = {row_q, col_q};
  assign x_off     = x_off_q;
  assign y_off     = y_off_q;

endmodule

// File: tb/tb_tile_locator.sv
// Randomized bench for tile_locator against a division-based board model,
// with directed points, backpressure and a mid-computation reset.
module tb_tile_locator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] xIn = 8'd0;
  logic [6:0] yIn = 7'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, hit;
  logic [1:0] tile_col, tile_row;
  logic [3:0] tile_idx;
  logic [4:0] x_off, y_off;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  logic       exp_hit;
  logic [1:0] exp_col, exp_row;
  logic [3:0] exp_idx;
  logic [4:0] exp_xo, exp_yo;
  logic [18:0] cap_fields;
  int          cap_lat;

  tile_locator dut (
    .clk(clk), .reset(reset), .xIn(xIn), .yIn(yIn),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .tile_col(tile_col), .tile_row(tile_row), .tile_idx(tile_idx),
    .x_off(x_off), .y_off(y_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Board geometry from first principles: offset from origin, divide by pitch.
  task automatic model(input int x, input int y, output logic h, output int c, output int r,
                       output int xo, output int yo, output int lat);
    int lx, ly;
    lx = x - 36;
    ly = y - 4;
    h = 0; c = 0; r = 0; xo = 0; yo = 0; lat = 1;
    if (lx >= 0 && ly >= 0 && lx < 4 * 28 && ly < 4 * 28) begin
      h = 1;
      c = lx / 28;
      r = ly / 28;
      xo = lx % 28;
      yo = ly % 28;
      lat = ((c > r) ? c : r) + 2;
`ifdef TILE_LOCATOR_GAP_EN
      if (xo >= 28 - 2 || yo >= 28 - 2) begin
        h = 0; c = 0; r = 0; xo = 0; yo = 0;
      end
`endif
    end
  endtask

  function automatic logic [18:0] pack(logic h, logic [1:0] c, logic [1:0] r, logic [3:0] i,
                                      logic [4:0] xo, logic [4:0] yo);
    return {h, c, r, i, xo, yo};
  endfunction

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      check("result_fields", pack(hit, tile_col, tile_row, tile_idx, x_off, y_off),
            pack(exp_hit, exp_col, exp_row, exp_idx, exp_xo, exp_yo));
      check("busy_in_ready", in_ready, 0);
    end
  end

  task automatic query(input logic [7:0] x, input logic [6:0] y, input int hold);
    logic h;
    int c, r, xo, yo, lat, n;
    model(int'(x), int'(y), h, c, r, xo, yo, lat);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    exp_hit = h;
    exp_col = 2'(c);
    exp_row = 2'(r);
    exp_idx = 4'(r * 4 + c);
    exp_xo  = 5'(xo);
    exp_yo  = 5'(yo);
    xIn = x;
    yIn = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    xIn = 8'($urandom);
    yIn = 7'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      in_valid = 1'($urandom_range(0, 1));
      xIn = 8'($urandom);
    end
    check("latency", n, lat);
    cap_lat = n;
    cap_fields = pack(hit, tile_col, tile_row, tile_idx, x_off, y_off);
    repeat (hold) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      xIn = 8'($urandom);
      yIn = 7'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic lit(input string name, input logic [18:0] fields, input int lat);
    check({name, "_fields"}, cap_fields, fields);
    check({name, "_latency"}, cap_lat, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_fields", pack(hit, tile_col, tile_row, tile_idx, x_off, y_off), 19'd0);
    mon_en = 1'b1;

    query(8'd36, 7'd4, 0);
    lit("origin", pack(1, 0, 0, 0, 0, 0), 2);
    query(8'd100, 7'd40, 10);
    lit("mid_bp", pack(1, 2, 1, 6, 8, 8), 4);
    query(8'd35, 7'd50, 0);
    lit("left_miss", 19'd0, 1);
    query(8'd148, 7'd50, 0);
    lit("right_miss", 19'd0, 1);
`ifdef TILE_LOCATOR_GAP_EN
    query(8'd147, 7'd115, 0);
    lit("corner_gap", 19'd0, 5);
    query(8'd63, 7'd10, 0);
    lit("gap_px", 19'd0, 2);
`else
    query(8'd147, 7'd115, 0);
    lit("corner", pack(1, 3, 3, 15, 27, 27), 5);
    query(8'd63, 7'd10, 0);
    lit("gap_px", pack(1, 0, 0, 0, 27, 6), 2);
`endif

    // Reset while the divider is iterating.
    @(negedge clk);
    xIn = 8'd147;
    yIn = 7'd115;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_fields", pack(hit, tile_col, tile_row, tile_idx, x_off, y_off), 19'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 150; i++) begin
      if (i % 2 == 0)
        query(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), $urandom_range(0, 3));
      else
        query(8'($urandom_range(30, 155)), 7'($urandom_range(0, 125)), $urandom_range(0, 3));
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
